sistema_rega: RTL and testbench
===============================

// Module: sistema_rega
// PURPOSE
// Irrigation controller: a water tank with level sensors feeds a sprinkler pump or a drip valve.
// A Moore FSM fills the tank, irrigates on demand, drains/cleans the tank and traps sensor faults.
// Status appears on discrete outputs, a 7-segment digit and a scanned 5x7 LED matrix.
// Top-level block of the board design; all sensor inputs are pre-synchronised, static levels.
// PARAMETERS
// SCAN_DIV  1000  clock cycles each matrix column stays active (>=1)
// PORTS
// clock            in   1  system clock, all logic rising-edge
// reset            in   1  synchronous, active-high
// H, M, L          in   1  tank level sensors high/medium/low (1 = water at that sensor)
// T                in   1  temperature high (1 = hot) -> selects sprinkler vs drip
// Us               in   1  soil humidity (1 = soil wet)
// Ua               in   1  irrigation enable / air-dry flag (1 = irrigation allowed)
// Bs               out  1  sprinkler pump on
// Ag               out  1  drip (gotejamento) valve open
// Ve               out  1  inlet valve open (filling)
// Vs               out  1  outlet/drain valve open (cleaning)
// Al               out  1  alarm
// E                out  1  measurement error flag
// working          out  1  irrigation in progress
// led              out  1  tank-ready indicator
// segA..segG       out  1  7-seg segments, active-low
// seven_seg_digit  out  4  digit enables, active-low; constant 4'b1110 (digit 0 only)
// column           out  5  matrix column select, one-hot active-high
// lines            out  7  matrix row drive, active-low
// BEHAVIOUR
// Level code {H,M,L}: 000 empty(0), 001 low(1), 010 medium(2), 100 full(3); >1 bit set = invalid.
// req = ~Us & Ua. States (3-bit reg): FILLING, FULL_BOX, SPRINKLER, DRIP, CLEANING, ERROR.
// Next state registered; one clock from input change to new state/outputs. Invalid code -> ERROR
// from every state, highest priority. Other transitions (else hold):
//  FILLING:   H=1 -> FULL_BOX.
//  FULL_BOX:  req & T -> SPRINKLER; req & ~T -> DRIP.
//  SPRINKLER/DRIP: L=1 or ~req -> CLEANING (both at once: CLEANING, single transition).
//  CLEANING:  code 000 -> FILLING.
//  ERROR:     code valid -> FILLING (any valid code, incl. 100; FILLING then exits next cycle).
// Moore outputs from state only: FILLING Ve=1; FULL_BOX led=1; SPRINKLER Bs=1,working=1;
//  DRIP Ag=1,working=1; CLEANING Vs=1; ERROR E=1,Al=1. All unlisted outputs 0.
// Reset: state=FILLING, scan counter=0, column=5'b00001; all outputs registered/decoded to FILLING values.
// 7-seg: shows level digit 0..3 from current inputs; shows 'E' when state==ERROR (state wins).
// Matrix: column rotates left by one every SCAN_DIV clocks, 5'b10000 wraps to 5'b00001.
//  Rows lit (low) bottom-up: empty 0, low 2, medium 4, full 7, identical in every column;
//  ERROR state: all 7 rows lit. Counter wraps at SCAN_DIV-1 with no gap cycle.
// TESTING
// reset, {H,M,L}=000 -> FILLING: Ve=1, others 0, 7-seg '0', seven_seg_digit=1110.
// H=1 -> next clk FULL_BOX led=1; then Us=0,Ua=1,T=1 -> SPRINKLER Bs=1 working=1.
// In SPRINKLER set L=1,Ua=0 -> CLEANING Vs=1; {H,M,L}=000 -> FILLING Ve=1.
// FULL_BOX with Us=0,Ua=1,T=0 -> DRIP Ag=1 working=1; L=1 -> CLEANING.
// {H,M,L}=111 in any state -> ERROR E=1 Al=1, 7-seg 'E', all rows lit; 000 -> FILLING.
// SPRINKLER + reset high -> FILLING next clk; column walks 00001->...->10000->00001 per SCAN_DIV.

Source files
------------

// File: rtl/sistema_rega.sv
// Irrigation controller: tank fill / sprinkler / drip / drain FSM with 7-seg and 5x7 matrix status.
// Latency: one clock from input change to new state and Moore outputs; display rows/segments follow inputs combinationally.
// Backpressure: none, free-running status outputs driven from static sensor levels.
module sistema_rega #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       T,
    input  logic       Us,
    input  logic       Ua,
    output logic       Bs,
    output logic       Ag,
    output logic       Ve,
    output logic       Vs,
    output logic       Al,
    output logic       E,
    output logic       working,
    output logic       led,
    output logic       segA,
    output logic       segB,
    output logic       segC,
    output logic       segD,
    output logic       segE,
    output logic       segF,
    output logic       segG,
    output logic [3:0] seven_seg_digit,
    output logic [4:0] column,
    output logic [6:0] lines
);

    typedef enum logic [2:0] {
        FILLING   = 3'd0,
        FULL_BOX  = 3'd1,
        SPRINKLER = 3'd2,
        DRIP      = 3'd3,
        CLEANING  = 3'd4,
        ERROR     = 3'd5
    } state_t;

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    code;
    logic          code_valid;
    logic [1:0]    level;
    logic          req;
    logic          show_err;
    logic [6:0]    seg;
    logic [CW-1:0] scan_cnt;

    assign code = {H, M, L};
    assign req  = ~Us & Ua;

    // One-hot-or-zero sensor code maps to a level 0..3; anything else is a sensor fault.
    always_comb begin
        code_valid = 1'b1;
        level      = 2'd0;
        case (code)
            3'b000:  level = 2'd0;
            3'b001:  level = 2'd1;
            3'b010:  level = 2'd2;
            3'b100:  level = 2'd3;
            default: code_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILLING;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!code_valid) begin
            state_nxt = ERROR;
        end else begin
            case (state)
                FILLING: begin
                    if (H) state_nxt = FULL_BOX;
                end
                FULL_BOX: begin
                    if (req) state_nxt = T ? SPRINKLER : DRIP;
                end
                SPRINKLER, DRIP: begin
                    if (L || !req) state_nxt = CLEANING;
                end
                CLEANING: begin
                    if (code == 3'b000) state_nxt = FILLING;
                end
                ERROR:   state_nxt = FILLING;
                default: state_nxt = FILLING;
            endcase
        end
    end

    always_comb begin
        Bs      = 1'b0;
        Ag      = 1'b0;
        Ve      = 1'b0;
        Vs      = 1'b0;
        Al      = 1'b0;
        E       = 1'b0;
        working = 1'b0;
        led     = 1'b0;
        case (state)
            FILLING:   Ve = 1'b1;
            FULL_BOX:  led = 1'b1;
            SPRINKLER: begin
                Bs      = 1'b1;
                working = 1'b1;
            end
            DRIP: begin
                Ag      = 1'b1;
                working = 1'b1;
            end
            CLEANING:  Vs = 1'b1;
            ERROR: begin
                E  = 1'b1;
                Al = 1'b1;
            end
            default: ;
        endcase
    end

    // A fault code shows the error glyph and full matrix even before the FSM lands in ERROR.
    assign show_err = (state == ERROR) || !code_valid;

    always_comb begin
        seg = 7'b1111111;
        if (show_err) begin
            seg = 7'b0110000;
        end else begin
            case (level)
                2'd0: seg = 7'b0000001;
                2'd1: seg = 7'b1001111;
                2'd2: seg = 7'b0010010;
                2'd3: seg = 7'b0000110;
                default: seg = 7'b1111111;
            endcase
        end
    end

    assign {segA, segB, segC, segD, segE, segF, segG} = seg;
    assign seven_seg_digit = 4'b1110;

    // lines[0] is the bottom row; a lit row is driven low.
    always_comb begin
        lines = 7'b1111111;
        if (show_err) begin
            lines = 7'b0000000;
        end else begin
            case (level)
                2'd0: lines = 7'b1111111;
                2'd1: lines = 7'b1111100;
                2'd2: lines = 7'b1110000;
                2'd3: lines = 7'b0000000;
                default: lines = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            column   <= 5'b00001;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            column   <= {column[3:0], column[4]};
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_sistema_rega.sv
// Scoreboard bench for sistema_rega: a spec-level model pushes expected outputs per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_sistema_rega;

    localparam int SCAN_DIV = 3;

    typedef enum int {S_FILL, S_FULL, S_SPR, S_DRIP, S_CLEAN, S_ERR} mstate_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       H, M, L, T, Us, Ua;
    logic       Bs, Ag, Ve, Vs, Al, E, working, led;
    logic       segA, segB, segC, segD, segE, segF, segG;
    logic [3:0] seven_seg_digit;
    logic [4:0] column;
    logic [6:0] lines;

    int checks = 0;
    int fails  = 0;

    logic [30:0] exp_q[$];
    mstate_t     m_state;
    int          m_cnt;

    sistema_rega #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock(clock), .reset(reset),
        .H(H), .M(M), .L(L), .T(T), .Us(Us), .Ua(Ua),
        .Bs(Bs), .Ag(Ag), .Ve(Ve), .Vs(Vs), .Al(Al), .E(E),
        .working(working), .led(led),
        .segA(segA), .segB(segB), .segC(segC), .segD(segD),
        .segE(segE), .segF(segF), .segG(segG),
        .seven_seg_digit(seven_seg_digit), .column(column), .lines(lines)
    );

    always #5 clock = ~clock;

    function automatic mstate_t model_next(mstate_t s, logic [2:0] hml, logic t, logic us, logic ua);
        logic req;
        req = !us && ua;
        if ($countones(hml) > 1) return S_ERR;
        case (s)
            S_FILL:  return hml[2] ? S_FULL : S_FILL;
            S_FULL:  return req ? (t ? S_SPR : S_DRIP) : S_FULL;
            S_SPR, S_DRIP: return (hml[0] || !req) ? S_CLEAN : s;
            S_CLEAN: return (hml == 3'b000) ? S_FILL : S_CLEAN;
            default: return S_FILL;
        endcase
    endfunction

    function automatic logic [30:0] model_out(mstate_t s, logic [2:0] hml, int cnt);
        logic [6:0] glyph[5];
        logic       bad;
        int         lvl;
        int         rows;
        logic [6:0] seg;
        logic [6:0] ln;
        logic [4:0] col;
        // Active-high {a..g} glyphs for 0,1,2,3,E.
        glyph[0] = 7'b1111110;
        glyph[1] = 7'b0110000;
        glyph[2] = 7'b1101101;
        glyph[3] = 7'b1111001;
        glyph[4] = 7'b1001111;
        bad = ($countones(hml) > 1) || (s == S_ERR);
        lvl = hml[2] ? 3 : hml[1] ? 2 : hml[0] ? 1 : 0;
        rows = bad ? 7 : (lvl == 0 ? 0 : lvl == 1 ? 2 : lvl == 2 ? 4 : 7);
        seg = bad ? ~glyph[4] : ~glyph[lvl];
        ln  = 7'(~((1 << rows) - 1));
        col = 5'(1 << ((cnt / SCAN_DIV) % 5));
        return {s == S_SPR, s == S_DRIP, s == S_FILL, s == S_CLEAN,
                s == S_ERR, s == S_ERR, (s == S_SPR) || (s == S_DRIP), s == S_FULL,
                seg, 4'b1110, col, ln};
    endfunction

    task automatic step(input logic [2:0] hml, input logic t, input logic us,
                        input logic ua, input logic rst);
        @(posedge clock);
        #1;
        {H, M, L} = hml;
        T = t; Us = us; Ua = ua; reset = rst;
        exp_q.push_back(model_out(m_state, hml, m_cnt));
        if (rst) begin
            m_state = S_FILL;
            m_cnt   = 0;
        end else begin
            m_state = model_next(m_state, hml, t, us, ua);
            m_cnt   = m_cnt + 1;
        end
    endtask

    initial begin : monitor
        logic [30:0] got;
        logic [30:0] want;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got = {Bs, Ag, Ve, Vs, Al, E, working, led,
                       segA, segB, segC, segD, segE, segF, segG,
                       seven_seg_digit, column, lines};
                checks++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL outputs t=%0t got=%b required=%b", $time, got, want);
                end
            end
        end
    end

    initial begin : stimulus
        logic [2:0] codes[4];
        logic [2:0] hml;
        int         wait_cnt;
        codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b100;
        reset = 1'b1;
        {H, M, L} = 3'b000;
        T = 1'b0; Us = 1'b1; Ua = 1'b0;
        repeat (2) @(posedge clock);
        m_state = S_FILL;
        m_cnt   = 0;

        // Directed walk: fill, sprinkler, clean, drip, fault, reset in sprinkler.
        step(3'b000, 0, 1, 0, 1);
        step(3'b000, 0, 1, 0, 0);
        step(3'b100, 0, 1, 0, 0);
        step(3'b100, 1, 0, 1, 0);
        step(3'b010, 1, 0, 1, 0);
        step(3'b001, 1, 0, 0, 0);
        step(3'b001, 1, 0, 0, 0);
        step(3'b000, 1, 0, 0, 0);
        step(3'b100, 0, 0, 1, 0);
        step(3'b100, 0, 0, 1, 0);
        step(3'b010, 0, 0, 1, 0);
        step(3'b001, 0, 0, 1, 0);
        step(3'b000, 0, 0, 1, 0);
        step(3'b111, 0, 0, 1, 0);
        step(3'b111, 0, 0, 1, 0);
        step(3'b000, 0, 0, 1, 0);
        step(3'b100, 1, 0, 1, 0);
        step(3'b100, 1, 0, 1, 0);
        step(3'b100, 1, 0, 1, 0);
        step(3'b100, 1, 0, 1, 1);
        step(3'b000, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(3'b000, 0, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) hml = 3'($urandom);
            else hml = codes[$urandom_range(0, 3)];
            step(hml, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
